// File: rtl/ram_arbiter.sv
// Round-robin arbiter for a single-port RAM shared by the CPU (req 0) and the debug/loader (req 1).
// Optional grant counters are enabled with the macro RAM_ARB_STATS_EN.
module ram_arbiter #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic          r0_lock,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic          r1_lock,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] ram_a,
  output logic          ram_re,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [15:0]   stat0,
  output logic [15:0]   stat1
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  localparam logic [3:0] BurstLim = 4'(MAX_BURST - 1);

  state_e        r_state, w_state_nxt;
  logic          r_last, w_last_nxt;
  logic [3:0]    r_burst, w_burst_nxt;
  logic [3:0]    w_burst_inc;
  logic          w_gnt0, w_gnt1;
  logic          w_keep0, w_keep1;
  logic          w_pick0, w_pick1;
  logic          r_rvalid0, r_rvalid1;
  logic [DW-1:0] r_rdata0, r_rdata1;

  assign w_burst_inc = (r_burst == 4'hF) ? r_burst : r_burst + 4'd1;

  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_burst_nxt = r_burst;
    // Owner keeps the RAM unless the other side is waiting and the burst budget is spent
    w_keep0 = (r_state == StOwn0) && r0_req && (!r1_req || (r_burst < BurstLim));
    w_keep1 = (r_state == StOwn1) && r1_req && (!r0_req || (r_burst < BurstLim));
    w_pick0 = r0_req && (!r1_req || r_last);
    w_pick1 = r1_req && !w_pick0;
    if (!rst) begin
      if (w_keep0) begin
        w_gnt0      = 1'b1;
        w_state_nxt = r0_lock ? StOwn0 : StIdle;
        w_burst_nxt = r0_lock ? w_burst_inc : 4'd0;
      end else if (w_keep1) begin
        w_gnt1      = 1'b1;
        w_state_nxt = r1_lock ? StOwn1 : StIdle;
        w_burst_nxt = r1_lock ? w_burst_inc : 4'd0;
      end else if (w_pick0) begin
        w_gnt0      = 1'b1;
        w_last_nxt  = 1'b0;
        w_state_nxt = r0_lock ? StOwn0 : StIdle;
        w_burst_nxt = 4'd0;
      end else if (w_pick1) begin
        w_gnt1      = 1'b1;
        w_last_nxt  = 1'b1;
        w_state_nxt = r1_lock ? StOwn1 : StIdle;
        w_burst_nxt = 4'd0;
      end else begin
        w_state_nxt = StIdle;
        w_burst_nxt = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_last    <= 1'b1;
      r_burst   <= 4'd0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_burst   <= w_burst_nxt;
      r_rvalid0 <= w_gnt0 & ~r0_we;
      r_rvalid1 <= w_gnt1 & ~r1_we;
      if (w_gnt0 && !r0_we) r_rdata0 <= ram_rdata;
      if (w_gnt1 && !r1_we) r_rdata1 <= ram_rdata;
    end
  end

  assign r0_gnt    = w_gnt0;
  assign r1_gnt    = w_gnt1;
  assign r0_rvalid = r_rvalid0;
  assign r1_rvalid = r_rvalid1;
  assign r0_rdata  = r_rdata0;
  assign r1_rdata  = r_rdata1;

  assign ram_a     = w_gnt0 ? r0_addr  : (w_gnt1 ? r1_addr  : '0);
  assign ram_wdata = w_gnt0 ? r0_wdata : (w_gnt1 ? r1_wdata : '0);
  assign ram_re    = (w_gnt0 & ~r0_we) | (w_gnt1 & ~r1_we);
  assign ram_we    = (w_gnt0 & r0_we) | (w_gnt1 & r1_we);

`ifdef RAM_ARB_STATS_EN
  logic [15:0] r_stat0, r_stat1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat0 <= 16'd0;
      r_stat1 <= 16'd0;
    end else begin
      if (w_gnt0 && (r_stat0 != 16'hFFFF)) r_stat0 <= r_stat0 + 16'd1;
      if (w_gnt1 && (r_stat1 != 16'hFFFF)) r_stat1 <= r_stat1 + 16'd1;
    end
  end

  assign stat0 = r_stat0;
  assign stat1 = r_stat1;
`else
  assign stat0 = 16'd0;
  assign stat1 = 16'd0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised bench for ram_arbiter against a behavioural ownership/run-length model and RAM image.
// Build with RAM_ARB_STATS_EN defined to exercise the grant counters.
module tb_ram_arbiter;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_req = 0, r0_we = 0, r0_lock = 0;
  logic [15:0] r0_addr = 0;
  logic [3:0]  r0_wdata = 0;
  logic        r1_req = 0, r1_we = 0, r1_lock = 0;
  logic [15:0] r1_addr = 0;
  logic [3:0]  r1_wdata = 0;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [3:0]  r0_rdata, r1_rdata;
  logic [15:0] ram_a;
  logic        ram_re, ram_we;
  logic [3:0]  ram_wdata, ram_rdata;
  logic [15:0] stat0, stat1;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(16), .DW(4), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .ram_a(ram_a), .ram_re(ram_re), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stat0(stat0), .stat1(stat1)
  );

  // Bench-side RAM driven by the DUT, plus an independent reference image
  logic [3:0] mem     [0:65535];
  logic [3:0] ref_mem [0:65535];
  assign ram_rdata = ram_re ? mem[ram_a] : 4'h0;
  always @(posedge clk) if (ram_we) mem[ram_a] <= ram_wdata;

  wire [65:0] obs = {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
                     ram_re, ram_we, ram_a, ram_wdata, stat0, stat1};
  logic [65:0] exp_v;
  int n_vec = 0, n_err = 0;

  // Model: current owner (-1 none), last winner, grants so far in this ownership run
  int owner, last, run;
  logic e_rv0, e_rv1;
  logic [3:0] e_rd0, e_rd1;
  logic [15:0] e_st0, e_st1;

  task automatic model_reset();
    owner = -1; last = 1; run = 0;
    e_rv0 = 0; e_rv1 = 0; e_rd0 = 0; e_rd1 = 0; e_st0 = 0; e_st1 = 0;
  endtask

  task automatic apply(input logic rs,
                       input logic q0, input logic w0, input logic k0,
                       input logic [15:0] a0, input logic [3:0] d0,
                       input logic q1, input logic w1, input logic k1,
                       input logic [15:0] a1, input logic [3:0] d1);
    logic [1:0] req, lk;
    int win;
    logic g0, g1, ere, ewe;
    logic [15:0] ea;
    logic [3:0] ed;
    @(negedge clk);
    rst = rs;
    r0_req = q0; r0_we = w0; r0_lock = k0; r0_addr = a0; r0_wdata = d0;
    r1_req = q1; r1_we = w1; r1_lock = k1; r1_addr = a1; r1_wdata = d1;
    #1;
    req = {q1, q0}; lk = {k1, k0};
    win = -1;
    if (!rs) begin
      if (owner >= 0 && req[owner] && (!req[1-owner] || run < MB)) win = owner;
      else if (req[0] && req[1]) win = 1 - last;
      else if (req[0]) win = 0;
      else if (req[1]) win = 1;
    end
    g0 = (win == 0); g1 = (win == 1);
    ea  = g0 ? a0 : (g1 ? a1 : 16'h0);
    ed  = g0 ? d0 : (g1 ? d1 : 4'h0);
    ere = (g0 && !w0) || (g1 && !w1);
    ewe = (g0 && w0) || (g1 && w1);
    exp_v = {g0, g1, e_rv0, e_rv1, e_rd0, e_rd1, ere, ewe, ea, ed, e_st0, e_st1};
    if (rs) model_reset();
    else begin
      e_rv0 = g0 && !w0;
      e_rv1 = g1 && !w1;
      if (e_rv0) e_rd0 = ref_mem[a0];
      if (e_rv1) e_rd1 = ref_mem[a1];
      if (ewe) ref_mem[ea] = ed;
      if (win >= 0) begin
        run = (win == owner) ? run + 1 : 1;
        owner = lk[win] ? win : -1;
        if (owner < 0) run = 0;
        last = win;
      end else begin
        owner = -1; run = 0;
      end
`ifdef RAM_ARB_STATS_EN
      if (g0 && e_st0 != 16'hFFFF) e_st0++;
      if (g1 && e_st1 != 16'hFFFF) e_st1++;
`endif
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1, 1, 0, 1, 16'h0003, 4'h0, 1, 1, 0, 16'h0004, 4'h5);
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL reset[%0d] got=%h want=%h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_round_robin();
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      logic q = (i < 4);
      apply(0, q, 0, 0, 16'($urandom), 0, q, 0, 0, 16'($urandom), 0);
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL rr[%0d] got=%h want=%h", i, obs, exp_v);
      end
      if (i < 4) begin
        n_vec++;
        if ({r0_gnt, r1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_err++; $display("FAIL rr_order[%0d] got=%b%b want r%0d", i, r0_gnt, r1_gnt, i % 2);
        end
      end
    end
  endtask

  task automatic test_write_read();
    apply(0, 1, 1, 0, 16'h0010, 4'hA, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL wr got=%h want=%h", obs, exp_v); end
    apply(0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0010, 0);
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL rd got=%h want=%h", obs, exp_v); end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL rd_ret got=%h want=%h", obs, exp_v); end
    n_vec++;
    if ({r1_rvalid, r1_rdata} !== 5'h1A) begin
      n_err++; $display("FAIL rd_data got=%b/%h want 1/a", r1_rvalid, r1_rdata);
    end
  endtask

  task automatic test_burst();
    int wait1 = 0, max_wait = 0;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      apply(0, 1, 0, 1, 16'($urandom), 0, 1, 0, 0, 16'($urandom), 0);
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL burst[%0d] got=%h want=%h", i, obs, exp_v);
      end
      if (i < 5) begin
        n_vec++;
        if (r1_gnt !== (i == 4)) begin
          n_err++; $display("FAIL burst_seq[%0d] r1_gnt got=%b want=%b", i, r1_gnt, i == 4);
        end
      end
      if (r1_gnt) wait1 = 0; else wait1++;
      if (wait1 > max_wait) max_wait = wait1;
    end
    n_vec++;
    if (max_wait > MB) begin
      n_err++; $display("FAIL starve r1 waited=%0d limit=%0d", max_wait, MB);
    end
  endtask

  task automatic test_solo_lock();
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'(i), 0);
      n_vec++;
      if (obs !== exp_v || r1_gnt !== 1'b1) begin
        n_err++; $display("FAIL solo[%0d] got=%h want=%h", i, obs, exp_v);
      end
    end
    // Owner drops out; r0 takes over and must then receive a full fresh burst
    for (int i = 0; i < 7; i++) begin
      apply(0, 1, 0, 1, 16'(i + 32), 0, (i > 0), 0, 0, 16'h0040, 0);
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL solo_release[%0d] got=%h want=%h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      apply(0, 1, 0, 1, 16'h0007, 0, 1, 0, 0, 16'h0008, 0);
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL mid[%0d] got=%h want=%h", i, obs, exp_v); end
    end
    apply(1, 1, 0, 1, 16'h0007, 0, 1, 0, 0, 16'h0008, 0);
    n_vec++;
    if (obs !== exp_v || {r0_gnt, r1_gnt, ram_re, ram_we} !== 4'b0) begin
      n_err++; $display("FAIL mid_rst got=%h want=%h", obs, exp_v);
    end
    apply(0, 1, 0, 0, 16'h0009, 0, 1, 0, 0, 16'h000A, 0);
    n_vec++;
    if ({r0_rvalid, r1_rvalid, r0_rdata, r1_rdata, r0_gnt, r1_gnt} !== 12'b00_0000_0000_10) begin
      n_err++; $display("FAIL mid_after got=%b want=000000000010",
                        {r0_rvalid, r1_rvalid, r0_rdata, r1_rdata, r0_gnt, r1_gnt});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 59) == 0),
            1'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0),
            16'($urandom_range(0, 15)), 4'($urandom),
            1'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0),
            16'($urandom_range(0, 15)), 4'($urandom));
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL rand[%0d] got=%h want=%h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_stats();
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) apply(0, (i < 5), 1, 0, 16'h0100, 0, (i >= 5), 1, 0, 16'h0101, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++;
`ifdef RAM_ARB_STATS_EN
    if ({stat0, stat1} !== {16'd5, 16'd3}) begin
      n_err++; $display("FAIL stats got=%0d/%0d want=5/3", stat0, stat1);
    end
    for (int i = 0; i < 65535; i++) apply(0, 1, 1, 0, 16'h0200, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if ({stat0, stat1} !== {16'hFFFF, 16'd3}) begin
      n_err++; $display("FAIL stats_sat got=%h/%h want=ffff/0003", stat0, stat1);
    end
`else
    if ({stat0, stat1} !== 32'd0) begin
      n_err++; $display("FAIL stats_off got=%h/%h want=0/0", stat0, stat1);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 4'(i ^ (i >> 4) ^ 5);
      ref_mem[i] = 4'(i ^ (i >> 4) ^ 5);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    test_reset();
    test_round_robin();
    test_write_read();
    test_burst();
    test_solo_lock();
    test_reset_mid();
    test_random();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Arbitrates the single-port 4-bit data RAM between two requesters:
  - requester 0: the CPU core;
  - requester 1: the debug/loader port.
- Grants at most one RAM access per cycle.
- Round-robin fairness, with optional short lock bursts.
- Registers read data back to the granted requester.
- Sits between the core's RAM control (addr/re/we/data) and the `ram` instance.

Parameters:
- AW, 16, address width.
- DW, 4, data width.
- MAX_BURST, 4, maximum consecutive locked grants to one requester while the other is waiting (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- r0_req  input  1  requester 0 access request.
- r0_we  input  1  requester 0 write (1) / read (0).
- r0_lock  input  1  requester 0 asks to keep ownership next cycle.
- r0_addr  input  AW  requester 0 address.
- r0_wdata  input  DW  requester 0 write data.
- r0_gnt  output  1  requester 0 access performed this cycle.
- r0_rvalid  output  1  requester 0 read data valid (one cycle after a read grant).
- r0_rdata  output  DW  requester 0 read data.
- r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as requester 0, for requester 1.
- ram_a  output  AW  RAM address.
- ram_re  output  1  RAM read enable.
- ram_we  output  1  RAM write enable.
- ram_wdata  output  DW  RAM write data.
- ram_rdata  input  DW  RAM read data (combinational from ram_a/ram_re).
- stat0  output  16  grant count, requester 0 (see Optional Feature).
- stat1  output  16  grant count, requester 1 (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, last=1 (so requester 0 wins first), burst=0.
  - All gnt/rvalid=0; rdata=0; stats=0.
  - Reset mid-burst drops ownership; no RAM strobe in the reset cycle.
- Grant is combinational from the current state and requests.
  - The access happens in the same cycle: ram_re=gnt & ~we, ram_we=gnt & we.
  - The RAM mux selects the granted requester's addr/wdata; with no grant, ram_a/ram_wdata=0 and both enables=0.
- State machine states: IDLE, OWN0, OWN1.
- IDLE:
  - One request pending: grant it.
  - Both pending: grant the requester != last.
  - Next state = OWNx if the granted requester has lock=1, else IDLE.
  - Update last to the granted requester.
- OWNx with rx_req=1:
  - Grant x unconditionally if the other requester is idle.
  - If the other is requesting, grant x only while burst < MAX_BURST-1; otherwise grant the other, go to IDLE (or OWNother if its lock=1), and clear burst.
- OWNx with rx_req=0: no grant to x. Act as IDLE this cycle (the other may be granted); ownership is lost.
- burst:
  - Increments on each consecutive locked grant to the same owner.
  - Clears on a change of owner or on return to IDLE.
  - 4-bit, never wraps.
- Read return:
  - Read grant at cycle N: rx_rvalid=1 and rx_rdata=ram_rdata (registered) at cycle N+1.
  - rdata holds its value when rvalid=0.
  - Writes produce no rvalid.
- Simultaneous read grant to one requester and later read by the other: rvalid pulses are per requester and never overlap in the same cycle.
- No starvation: a requester with req held waits at most MAX_BURST cycles.

Optional Feature:
- Macro RAM_ARB_STATS_EN.
- Defined:
  - stat0/stat1 increment by 1 on each cycle the respective gnt=1.
  - 16-bit, saturate at 16'hFFFF.
  - Cleared by rst.
- Undefined: no counter logic; stat0/stat1 tied to 0.
- Arbitration timing is identical in both cases.

Test Plan:
- rst, then r0_req=r1_req=1 reads (lock=0) for 4 cycles -> gnt order r0,r1,r0,r1; each rvalid follows its grant one cycle later with the RAM contents.
- r0 writes addr 16'h0010 data 4'hA, then r1 reads 16'h0010 -> r1_rvalid one cycle after its grant, r1_rdata=4'hA.
- r0_lock=1, r0_req=1 held, r1_req=1 held, MAX_BURST=4 -> r0 granted 4 consecutive cycles, then r1 granted; r1 waits no more than 4 cycles.
- r1_lock=1, r1 alone requesting for 10 cycles -> r1_gnt=1 all 10 cycles (no forced release without contention); then r1_req=0 -> state returns to IDLE, burst=0.
- rst asserted during an OWN0 burst with a read granted -> next cycle all gnt/rvalid=0, rdata=0; after release r0 wins the first tie.
- RAM_ARB_STATS_EN defined: 5 r0 grants and 3 r1 grants -> stat0=5, stat1=3; preload stat0 near 16'hFFFF -> holds at 16'hFFFF. Undefined: stat0=stat1=0 throughout.
